// File: rtl/data_memory_ctrl.sv
// Handshaked byte-addressed data memory for the MIPS datapath: byte/half/word
// loads and stores, sign/zero extension, misalignment detection, wait states.
module data_memory_ctrl #(
  parameter int    ADDR_W      = 12,
  parameter int    WAIT_CYCLES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              Req,
  input  logic              WE,
  input  logic [1:0]        Size,
  input  logic              Unsigned,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       WData,
  output logic              Ready,
  output logic              Done,
  output logic [31:0]       RData,
  output logic              Misalign
);

  localparam int         DEPTH     = 1 << (ADDR_W - 2);
  localparam bit         HAS_WAIT  = (WAIT_CYCLES > 0);
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_e;

  state_e              state_q;
  logic                ready_q;
  logic                done_q;
  logic                misalign_q;
  logic [31:0]         rdata_q;
  logic [3:0]          cnt_q;

  logic                we_q;
  logic [1:0]          size_q;
  logic                uns_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic                mis_q;

  logic [31:0]         mem_q [DEPTH];

  logic                misaligned;
  logic [ADDR_W-3:0]   word_idx;
  logic [31:0]         rd_word;
  logic [31:0]         rd_shift;
  logic [31:0]         rdata_d;
  logic [3:0]          be_d;
  logic [31:0]         wlane_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    misaligned = 1'b0;
    case (Size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = Addr[0];
      default: misaligned = |Addr[1:0];
    endcase
  end

  assign word_idx = addr_q[ADDR_W-1:2];
  assign rd_word  = mem_q[word_idx];
  assign rd_shift = rd_word >> {addr_q[1:0], 3'b000};

  always_comb begin
    rdata_d = rd_word;
    case (size_q)
      SZ_BYTE: rdata_d = {{24{~uns_q & rd_shift[7]}},  rd_shift[7:0]};
      SZ_HALF: rdata_d = {{16{~uns_q & rd_shift[15]}}, rd_shift[15:0]};
      default: rdata_d = rd_word;
    endcase
  end

  // Store data is replicated across lanes; the byte enables pick the live ones.
  always_comb begin
    be_d    = 4'b1111;
    wlane_d = wdata_q;
    case (size_q)
      SZ_BYTE: begin
        be_d    = 4'b0001 << addr_q[1:0];
        wlane_d = {4{wdata_q[7:0]}};
      end
      SZ_HALF: begin
        be_d    = addr_q[1] ? 4'b1100 : 4'b0011;
        wlane_d = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  // NOTE: the storage array has no reset; its contents survive RST_N and a
  // reset branch would prevent it from mapping onto RAM.
  always_ff @(posedge CLK) begin
    if (state_q == S_ACCESS && we_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be_d[b]) mem_q[word_idx][8*b +: 8] <= wlane_d[8*b +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      rdata_q    <= '0;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mis_q      <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (Req) begin
            we_q    <= WE;
            size_q  <= Size;
            uns_q   <= Unsigned;
            addr_q  <= Addr;
            wdata_q <= WData;
            mis_q   <= misaligned;
            ready_q <= 1'b0;
            if (misaligned) begin
              state_q <= S_RESP;
            end else if (HAS_WAIT) begin
              state_q <= S_WAIT;
              cnt_q   <= 4'd1;
            end else begin
              state_q <= S_ACCESS;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == WAIT_LAST) begin
            cnt_q   <= '0;
            state_q <= S_ACCESS;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_ACCESS: begin
          if (!we_q) rdata_q <= rdata_d;
          state_q <= S_RESP;
        end
        S_RESP: begin
          // Done/Misalign are registered here, so they are seen in the
          // first IDLE cycle, alongside the returning Ready.
          done_q     <= 1'b1;
          misalign_q <= mis_q;
          ready_q    <= 1'b1;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Ready    = ready_q;
  assign Done     = done_q;
  assign RData    = rdata_q;
  assign Misalign = misalign_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: directed vector table, reset abort, back-to-back
// latency on three wait-state builds, and random traffic against a byte model.
module tb_data_memory_ctrl;

  localparam int NI = 3;

  typedef struct {
    bit          we;
    logic [1:0]  size;
    bit          uns;
    logic [11:0] addr;
    logic [31:0] wdata;
  } op_t;

  typedef struct {
    op_t         op;
    logic [31:0] exp_rd;
    bit          exp_mis;
    int          exp_lat;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        req     [NI];
  logic        we      [NI];
  logic [1:0]  size    [NI];
  logic        uns     [NI];
  logic [11:0] addr    [NI];
  logic [31:0] wdata   [NI];
  logic        ready   [NI];
  logic        done    [NI];
  logic [31:0] rdata   [NI];
  logic        misalign[NI];

  int n_cmp  = 0;
  int n_fail = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    data_memory_ctrl #(
      .ADDR_W     (12),
      .WAIT_CYCLES(g == 0 ? 1 : (g == 1 ? 0 : 15)),
      .INIT_FILE  ("")
    ) dut (
      .CLK     (clk),
      .RST_N   (rst_n),
      .Req     (req[g]),
      .WE      (we[g]),
      .Size    (size[g]),
      .Unsigned(uns[g]),
      .Addr    (addr[g]),
      .WData   (wdata[g]),
      .Ready   (ready[g]),
      .Done    (done[g]),
      .RData   (rdata[g]),
      .Misalign(misalign[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: plain byte array per instance, little-endian assembly.
  logic [7:0]  mem_m   [NI][4096];
  bit          val_m   [NI][4096];
  logic [31:0] last_rd [NI];
  bit          rd_known[NI];

  function automatic int wc_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 0 : 15);
  endfunction

  function automatic op_t mk_op(input bit w, input logic [1:0] sz, input bit u,
                                input logic [11:0] a, input logic [31:0] d);
    op_t o;
    o.we = w; o.size = sz; o.uns = u; o.addr = a; o.wdata = d;
    return o;
  endfunction

  function automatic vec_t mk_vec(input op_t o, input logic [31:0] rd,
                                  input bit mis, input int lat);
    vec_t v;
    v.op = o; v.exp_rd = rd; v.exp_mis = mis; v.exp_lat = lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      last_rd[i]  = 32'h0;
      rd_known[i] = 1'b1;
    end
  endtask

  task automatic model_access(input int i, input op_t op, output logic [31:0] exp_rd,
                              output bit exp_mis, output int exp_lat, output bit rd_chk);
    int          n;
    int          a;
    logic [31:0] v;
    bit          ok;
    n       = (op.size == 2'd0) ? 1 : ((op.size == 2'd1) ? 2 : 4);
    a       = int'(op.addr);
    exp_mis = (a % n) != 0;
    exp_lat = exp_mis ? 1 : 2 + wc_of(i);
    if (!exp_mis) begin
      if (op.we) begin
        for (int k = 0; k < n; k++) begin
          mem_m[i][a+k] = op.wdata[8*k +: 8];
          val_m[i][a+k] = 1'b1;
        end
      end else begin
        v  = 32'h0;
        ok = 1'b1;
        for (int k = 0; k < n; k++) begin
          v  = v | (32'(mem_m[i][a+k]) << (8*k));
          ok = ok & val_m[i][a+k];
        end
        if (!op.uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        last_rd[i]  = v;
        rd_known[i] = ok;
      end
    end
    exp_rd = last_rd[i];
    rd_chk = rd_known[i];
  endtask

  task automatic apply(input int i, input op_t op);
    we[i] = op.we; size[i] = op.size; uns[i] = op.uns;
    addr[i] = op.addr; wdata[i] = op.wdata;
  endtask

  // Entered and left on a falling edge; inputs are scrambled after accept.
  task automatic dut_txn(input int i, input op_t op, output logic [31:0] rd,
                         output logic mis, output int lat, output bit rdy_ok);
    int guard;
    guard = 0;
    while (ready[i] !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    apply(i, op);
    req[i] = 1'b1;
    @(posedge clk);
    #1;
    req[i] = 1'b0;
    apply(i, mk_op(~op.we, ~op.size, ~op.uns, ~op.addr, ~op.wdata));
    lat    = 0;
    rdy_ok = 1'b1;
    forever begin
      @(negedge clk);
      if (done[i] === 1'b1) break;
      if (ready[i] !== 1'b0) rdy_ok = 1'b0;
      lat++;
      if (lat > 40) break;
    end
    if (ready[i] !== 1'b1) rdy_ok = 1'b0;
    rd  = rdata[i];
    mis = misalign[i];
  endtask

  task automatic run_op(input int i, input op_t op, input string tag);
    logic [31:0] e_rd, a_rd;
    bit          e_mis, chk, rdy_ok;
    logic        a_mis;
    int          e_lat, a_lat;
    model_access(i, op, e_rd, e_mis, e_lat, chk);
    dut_txn(i, op, a_rd, a_mis, a_lat, rdy_ok);
    check({tag, " latency"}, a_lat, e_lat);
    check({tag, " misalign"}, {31'b0, a_mis}, {31'b0, e_mis});
    if (chk) check({tag, " rdata"}, a_rd, e_rd);
  endtask

  task automatic burst(input int i);
    op_t         ops[4];
    int          acc_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] e_rd;
    bit          e_mis, chk, rdy_ok, rdy;
    int          e_lat, cyc, n_acc, n_done, extra, a;
    for (int k = 0; k < 4; k++)
      run_op(i, mk_op(1'b1, 2'b10, 1'b0, 12'h080 + 12'(4*k), $urandom), $sformatf("burst%0d preload", i));
    ops[0] = mk_op(1'b0, 2'b10, 1'b0, 12'h080, 32'h0);
    ops[1] = mk_op(1'b0, 2'b00, 1'b0, 12'h085, 32'h0);
    ops[2] = mk_op(1'b0, 2'b01, 1'b1, 12'h08A, 32'h0);
    ops[3] = mk_op(1'b0, 2'b10, 1'b0, 12'h08C, 32'h0);
    rdy_ok = 1'b1; n_acc = 0; n_done = 0; cyc = 0; extra = 0;
    apply(i, ops[0]);
    req[i] = 1'b1;
    while (n_done < 4 && cyc < 300) begin
      rdy = (ready[i] === 1'b1);
      @(posedge clk);
      cyc++;
      if (rdy && req[i]) begin
        model_access(i, ops[n_acc], e_rd, e_mis, e_lat, chk);
        acc_q.push_back(cyc);
        exp_q.push_back(e_rd);
        n_acc++;
        #1;
        if (n_acc == 4) req[i] = 1'b0;
        else apply(i, ops[n_acc]);
      end
      @(negedge clk);
      if (done[i] === 1'b1) begin
        if (acc_q.size() == 0) extra++;
        else begin
          a = acc_q.pop_front();
          check($sformatf("burst%0d latency", i), cyc - a, 2 + wc_of(i));
          check($sformatf("burst%0d rdata", i), rdata[i], exp_q.pop_front());
        end
        n_done++;
        if (ready[i] !== 1'b1) rdy_ok = 1'b0;
      end else if (acc_q.size() > 0 && ready[i] !== 1'b0) begin
        rdy_ok = 1'b0;
      end
    end
    req[i] = 1'b0;
    check($sformatf("burst%0d completions", i), n_done, 4);
    repeat (25) begin
      @(negedge clk);
      if (done[i] === 1'b1) extra++;
    end
    check($sformatf("burst%0d extra Done", i), extra, 0);
    check($sformatf("burst%0d Ready low while busy", i), {31'b0, rdy_ok}, 32'd1);
  endtask

  vec_t vecs[15];

  initial begin
    logic [31:0] a_rd;
    logic        a_mis;
    int          a_lat, seen;
    bit          rdy_ok;
    logic [31:0] d_rd;
    bit          d_mis, d_chk;
    int          d_lat;

    vecs[0]  = mk_vec(mk_op(1, 2'b10, 0, 12'h010, 32'hDEADBEEF), 32'h0000_0000, 0, 3);
    vecs[1]  = mk_vec(mk_op(0, 2'b10, 0, 12'h010, 32'h0),        32'hDEADBEEF, 0, 3);
    vecs[2]  = mk_vec(mk_op(1, 2'b00, 0, 12'h011, 32'h0000_007F), 32'hDEADBEEF, 0, 3);
    vecs[3]  = mk_vec(mk_op(1, 2'b00, 0, 12'h012, 32'h0000_0080), 32'hDEADBEEF, 0, 3);
    vecs[4]  = mk_vec(mk_op(0, 2'b10, 0, 12'h010, 32'h0),        32'hDE807FEF, 0, 3);
    vecs[5]  = mk_vec(mk_op(0, 2'b00, 0, 12'h012, 32'h0),        32'hFFFFFF80, 0, 3);
    vecs[6]  = mk_vec(mk_op(0, 2'b00, 1, 12'h012, 32'h0),        32'h0000_0080, 0, 3);
    vecs[7]  = mk_vec(mk_op(1, 2'b10, 0, 12'h020, 32'h12345678), 32'h0000_0080, 0, 3);
    vecs[8]  = mk_vec(mk_op(1, 2'b01, 0, 12'h022, 32'h0000_8001), 32'h0000_0080, 0, 3);
    vecs[9]  = mk_vec(mk_op(0, 2'b01, 0, 12'h022, 32'h0),        32'hFFFF8001, 0, 3);
    vecs[10] = mk_vec(mk_op(0, 2'b01, 1, 12'h022, 32'h0),        32'h0000_8001, 0, 3);
    vecs[11] = mk_vec(mk_op(0, 2'b10, 0, 12'h020, 32'h0),        32'h80015678, 0, 3);
    vecs[12] = mk_vec(mk_op(0, 2'b10, 0, 12'h013, 32'h0),        32'h80015678, 1, 1);
    vecs[13] = mk_vec(mk_op(1, 2'b01, 0, 12'h021, 32'h0000_ABCD), 32'h80015678, 1, 1);
    vecs[14] = mk_vec(mk_op(0, 2'b10, 0, 12'h020, 32'h0),        32'h80015678, 0, 3);

    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      req[i] = 1'b0;
      apply(i, mk_op(0, 2'b00, 0, 12'h0, 32'h0));
      for (int b = 0; b < 4096; b++) val_m[i][b] = 1'b0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("reset%0d Ready", i), {31'b0, ready[i]}, 32'd1);
      check($sformatf("reset%0d Done", i), {31'b0, done[i]}, 32'd0);
      check($sformatf("reset%0d RData", i), rdata[i], 32'h0);
      check($sformatf("reset%0d Misalign", i), {31'b0, misalign[i]}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 15; v++) begin
      model_access(0, vecs[v].op, d_rd, d_mis, d_lat, d_chk);
      dut_txn(0, vecs[v].op, a_rd, a_mis, a_lat, rdy_ok);
      check($sformatf("vec%0d rdata", v), a_rd, vecs[v].exp_rd);
      check($sformatf("vec%0d misalign", v), {31'b0, a_mis}, {31'b0, vecs[v].exp_mis});
      check($sformatf("vec%0d latency", v), a_lat, vecs[v].exp_lat);
      check($sformatf("vec%0d Ready", v), {31'b0, rdy_ok}, 32'd1);
    end

    // Store aborted by reset while waiting: memory keeps the older word.
    run_op(0, mk_op(1, 2'b10, 0, 12'h040, 32'h11223344), "pre-abort store");
    apply(0, mk_op(1, 2'b10, 0, 12'h040, 32'hAAAAAAAA));
    req[0] = 1'b1;
    @(posedge clk);
    #1 req[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("abort Ready", {31'b0, ready[0]}, 32'd1);
    check("abort Done", {31'b0, done[0]}, 32'd0);
    check("abort RData", rdata[0], 32'h0);
    check("abort Misalign", {31'b0, misalign[0]}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (done[0] === 1'b1) seen++;
    end
    check("abort no Done", seen, 0);
    run_op(0, mk_op(0, 2'b10, 0, 12'h040, 32'h0), "post-abort load");

    for (int i = 0; i < NI; i++) burst(i);

    for (int k = 0; k < 16; k++)
      run_op(0, mk_op(1, 2'b10, 0, 12'h100 + 12'(4*k), $urandom), "rand preload");
    for (int k = 0; k < 150; k++)
      run_op(0, mk_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 12'h100 + 12'($urandom_range(0, 63)),
                      $urandom), $sformatf("rand%0d", k));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
Parametrised successor to the single-cycle word data memory. Byte-addressed, handshaked data memory for the MIPS datapath. Supports byte, halfword and word loads and stores, with sign or zero extension and misalignment detection. A programmable number of wait states models slower memory, so the pipeline stalls on Ready/Done instead of assuming a combinational read.

Parameters:
ADDR_W, 12, byte-address width; storage is 2^(ADDR_W-2) 32-bit words; every address is in range.
WAIT_CYCLES, 1, extra cycles between accept and access, legal range 0..15.
INIT_FILE, "", if non-empty, load memory with $readmemh at elaboration; otherwise contents are unknown.

Ports:
CLK  input  1  clock, rising edge.
RST_N  input  1  asynchronous active-low reset.
Req  input  1  request; accepted on a rising CLK edge when Req & Ready.
WE  input  1  1 = store, 0 = load; sampled at accept.
Size  input  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
Unsigned  input  1  load extension: 1 = zero-extend, 0 = sign-extend.
Addr  input  ADDR_W  byte address; sampled at accept.
WData  input  32  store data, right-aligned (byte in [7:0], half in [15:0]); sampled at accept.
Ready  output  1  controller idle and able to accept.
Done  output  1  one-cycle pulse marking completion of the accepted request.
RData  output  32  load result; valid only while Done & ~WE_latched; holds its value otherwise.
Misalign  output  1  qualifies Done: request was misaligned and was not performed.

Behaviour:
- Reset (async, RST_N=0):
  - State = IDLE, Ready=1, Done=0, RData=0, Misalign=0, wait counter = 0.
  - Memory contents are not cleared.
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - Ready=1. On Req, latch WE, Size, Unsigned, Addr and WData.
  - Misaligned request (half with Addr[0]=1, or word with Addr[1:0]!=0): go to RESP with Misalign=1. No memory access and no wait states.
  - Aligned request: go to WAIT if WAIT_CYCLES>0, else to ACCESS.
- WAIT:
  - Counter counts 1..WAIT_CYCLES, then go to ACCESS.
  - Ready=0 in every state except IDLE.
- ACCESS (exactly one cycle):
  - Store: write the selected byte lanes of word Addr[ADDR_W-1:2] using byte enables.
    - Byte: lane Addr[1:0] gets WData[7:0].
    - Half: lanes {Addr[1],0} and {Addr[1],1} get WData[15:0], little-endian within the word.
    - Word: all four lanes.
    - Unselected lanes keep their old value.
  - Load: read the word, select the lane(s), extend to 32 bits per Unsigned, and register into RData at the end of ACCESS.
  - Go to RESP.
- RESP (one cycle):
  - Done=1; Misalign as determined at accept.
  - RData is updated only for successful loads; stores and misaligned requests leave RData unchanged.
  - Return to IDLE. Ready rises in the next cycle.
- Latency: request accepted at edge k gives Done high during the cycle after edge k+2+WAIT_CYCLES.
  - Aligned access: 3+WAIT_CYCLES cycles accept-to-accept.
  - Misaligned request: Done in the cycle after edge k+1.
- Back-to-back: Req held high is accepted again in the first IDLE cycle after RESP. Req while Ready=0 is ignored, not queued.
- Inputs change after accept: no effect; only the latched copies are used.
- Read-after-write to the same address in consecutive requests returns the new data. This is natural, because the write commits in ACCESS before the next accept.
- Reset mid-operation:
  - Reset in IDLE or WAIT aborts the request with no write and no Done.
  - Reset during ACCESS: a store on that cycle's edge may or may not commit. Both outcomes are acceptable; the bench must not check it.
- Debug: on each committed store, print the address and data with $display (simulation only, translate_off).

Test Plan:
- WAIT_CYCLES=1, word store Addr=0x010, WData=0xDEADBEEF, then word load Addr=0x010 -> Done 3 cycles after accept for each request; RData=0xDEADBEEF; Misalign=0.
- Byte store 0x7F to Addr=0x011 and 0x80 to Addr=0x012 over the word 0xDEADBEEF. Then word load of 0x010 -> 0xDE807FEF. Signed byte load of 0x012 -> 0xFFFFFF80. Unsigned byte load of 0x012 -> 0x00000080.
- Half store 0x8001 to Addr=0x022, then signed half load of 0x022 -> 0xFFFF8001; unsigned half load -> 0x00008001; word load of 0x020 -> upper half 0x8001 and lower half unchanged.
- Word load at Addr=0x013, then half store at Addr=0x021 -> each gives Done with Misalign=1 one cycle after accept; word 0x020 unchanged; RData holds its prior value.
- WAIT_CYCLES=0 and WAIT_CYCLES=15 builds, with Req held high for 4 loads -> accept-to-Done of 2 and 17 cycles respectively; Ready low from accept through RESP; no request dropped or duplicated.
- Store to Addr=0x040 with RST_N pulsed low during WAIT -> outputs return to reset values asynchronously; no Done; a subsequent load of 0x040 returns the pre-store value.
